// File: rtl/instr_fetch_unit_if.sv
// Bus bundle of the instruction fetch unit.
//  - Instruction-memory request channel: o_imem_req / o_imem_addr out, i_imem_gnt in.
//  - Instruction-memory response channel: i_imem_rvalid / i_imem_rdata in.
//  - Redirect from decode/execute: i_redirect / i_redirect_pc in.
//  - Instruction stream to the control unit: o_instr / o_pc / o_instr_vld out,
//    i_instr_rdy in.
// The o_/i_ prefixes are relative to the fetch unit, which connects through the
// master modport. The environment (memory, control unit) uses the slave modport.
interface instr_fetch_unit_if;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        o_instr_vld;
    logic        i_instr_rdy;

    modport master (
        output o_imem_req, o_imem_addr, o_instr, o_pc, o_instr_vld,
        input  i_imem_gnt, i_imem_rvalid, i_imem_rdata,
        input  i_redirect, i_redirect_pc, i_instr_rdy
    );

    modport slave (
        input  o_imem_req, o_imem_addr, o_instr, o_pc, o_instr_vld,
        output i_imem_gnt, i_imem_rvalid, i_imem_rdata,
        output i_redirect, i_redirect_pc, i_instr_rdy
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//  Front end of the single-cycle core. Owns the fetch PC, requests instruction
//  words over a req/gnt/rvalid handshake (one request outstanding at most) and
//  buffers {instruction, PC} pairs in a QDEPTH-entry FIFO whose head feeds the
//  control unit. A redirect flushes the FIFO and restarts fetching at the
//  word-aligned target; a response still in flight for the old path is dropped.
// Ports
//  i_clk    : clock, rising edge
//  i_rst_n  : synchronous active-low reset
//  bus      : instr_fetch_unit_if.master (imem request/response, redirect,
//             instruction stream; all outputs registered)
//  o_perf_fetch / o_perf_flush : FIFO push / redirect-cycle counters, present
//             only when IFU_PERF_CNT_EN is defined
// Parameters
//  RESET_PC : first PC fetched after reset
//  QDEPTH   : FIFO entries, power of 2, at least 2
// Configuration macro: IFU_PERF_CNT_EN
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
`ifdef IFU_PERF_CNT_EN
    output logic [31:0]        o_perf_fetch,
    output logic [31:0]        o_perf_flush,
`endif
    instr_fetch_unit_if.master bus
);
    localparam int unsigned      PTR_W   = $clog2(QDEPTH);
    localparam int unsigned      CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QDEPTH);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DROP  = 2'd2
    } ifu_state_t;

    ifu_state_t        state_r;
    ifu_state_t        state_nx_s;
    logic [31:0]       fetch_pc_r;
    logic [31:0]       fetch_pc_nx_s;
    logic [31:0]       req_addr_r;     // address of the request in flight
    logic [31:0]       req_addr_nx_s;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_nx_s;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_nx_s;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_nx_s;
    logic [31:0]       fifo_instr_r [QDEPTH];
    logic [31:0]       fifo_pc_r    [QDEPTH];
    logic              push_s;
    logic              pop_s;
    logic              flush_s;
    logic              req_r;
    logic              req_nx_s;
    logic              vld_r;
    logic              vld_nx_s;
    logic [31:0]       instr_r;
    logic [31:0]       instr_nx_s;
    logic [31:0]       pc_r;
    logic [31:0]       pc_nx_s;
    logic              unused_pc_bits_s;

    // Redirect targets are forced word aligned; the low bits are never used.
    assign unused_pc_bits_s = ^bus.i_redirect_pc[1:0];

    // FSM next state and per-cycle FIFO events; a redirect overrides everything else.
    always_comb begin
        state_nx_s    = state_r;
        fetch_pc_nx_s = fetch_pc_r;
        req_addr_nx_s = req_addr_r;
        push_s        = 1'b0;
        pop_s         = 1'b0;
        flush_s       = 1'b0;
        if (bus.i_redirect) begin
            flush_s       = 1'b1;
            fetch_pc_nx_s = {bus.i_redirect_pc[31:2], 2'b00};
            case (state_r)
                // A request granted in the redirect cycle is now on the dead path.
                ST_FETCH: begin
                    if (req_r && bus.i_imem_gnt) begin
                        state_nx_s = ST_DROP;
                    end else begin
                        state_nx_s = ST_FETCH;
                    end
                end
                // If the old response lands in this very cycle it is discarded here.
                ST_WAIT, ST_DROP: begin
                    if (bus.i_imem_rvalid) begin
                        state_nx_s = ST_FETCH;
                    end else begin
                        state_nx_s = ST_DROP;
                    end
                end
                default: state_nx_s = ST_FETCH;
            endcase
        end else begin
            pop_s = vld_r && bus.i_instr_rdy;
            case (state_r)
                ST_FETCH: begin
                    if (req_r && bus.i_imem_gnt) begin
                        req_addr_nx_s = fetch_pc_r;
                        fetch_pc_nx_s = fetch_pc_r + 32'd4;
                        state_nx_s    = ST_WAIT;
                    end else begin
                        state_nx_s    = ST_FETCH;
                    end
                end
                ST_WAIT: begin
                    if (bus.i_imem_rvalid) begin
                        push_s     = 1'b1;
                        state_nx_s = ST_FETCH;
                    end else begin
                        state_nx_s = ST_WAIT;
                    end
                end
                ST_DROP: begin
                    if (bus.i_imem_rvalid) begin
                        state_nx_s = ST_FETCH;
                    end else begin
                        state_nx_s = ST_DROP;
                    end
                end
                default: state_nx_s = ST_FETCH;
            endcase
        end
    end

    // FIFO bookkeeping plus the next value of every registered output.
    always_comb begin
        count_nx_s  = count_r;
        rd_ptr_nx_s = rd_ptr_r;
        wr_ptr_nx_s = wr_ptr_r;
        instr_nx_s  = instr_r;
        pc_nx_s     = pc_r;
        if (flush_s) begin
            count_nx_s  = {CNT_W{1'b0}};
            rd_ptr_nx_s = {PTR_W{1'b0}};
            wr_ptr_nx_s = {PTR_W{1'b0}};
        end else begin
            count_nx_s  = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
            rd_ptr_nx_s = rd_ptr_r + PTR_W'(pop_s);
            wr_ptr_nx_s = wr_ptr_r + PTR_W'(push_s);
        end
        // Head after this edge: the word being pushed when it lands at the new
        // read pointer (FIFO was empty or drained), otherwise stored data.
        if (count_nx_s != {CNT_W{1'b0}}) begin
            if (push_s && (wr_ptr_r == rd_ptr_nx_s)) begin
                instr_nx_s = bus.i_imem_rdata;
                pc_nx_s    = req_addr_r;
            end else begin
                instr_nx_s = fifo_instr_r[rd_ptr_nx_s];
                pc_nx_s    = fifo_pc_r[rd_ptr_nx_s];
            end
        end else begin
            instr_nx_s = instr_r;
            pc_nx_s    = pc_r;
        end
        vld_nx_s = (count_nx_s != {CNT_W{1'b0}});
        req_nx_s = (state_nx_s == ST_FETCH) && (count_nx_s < DEPTH_C);
    end

    // State, PC, FIFO storage and output registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r    <= ST_FETCH;
            fetch_pc_r <= RESET_PC;
            req_addr_r <= RESET_PC;
            count_r    <= {CNT_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            req_r      <= 1'b0;
            vld_r      <= 1'b0;
            instr_r    <= 32'h0000_0000;
            pc_r       <= RESET_PC;
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                fifo_instr_r[i] <= 32'h0000_0000;
                fifo_pc_r[i]    <= RESET_PC;
            end
        end else begin
            state_r    <= state_nx_s;
            fetch_pc_r <= fetch_pc_nx_s;
            req_addr_r <= req_addr_nx_s;
            count_r    <= count_nx_s;
            rd_ptr_r   <= rd_ptr_nx_s;
            wr_ptr_r   <= wr_ptr_nx_s;
            req_r      <= req_nx_s;
            vld_r      <= vld_nx_s;
            instr_r    <= instr_nx_s;
            pc_r       <= pc_nx_s;
            if (push_s) begin
                fifo_instr_r[wr_ptr_r] <= bus.i_imem_rdata;
                fifo_pc_r[wr_ptr_r]    <= req_addr_r;
            end
        end
    end

    assign bus.o_imem_req  = req_r;
    assign bus.o_imem_addr = fetch_pc_r;
    assign bus.o_instr     = instr_r;
    assign bus.o_pc        = pc_r;
    assign bus.o_instr_vld = vld_r;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_r;
    logic [31:0] perf_flush_r;

    // Free-running event counters: accepted fetches and redirect cycles.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            perf_fetch_r <= 32'd0;
            perf_flush_r <= 32'd0;
        end else begin
            perf_fetch_r <= perf_fetch_r + {31'd0, push_s};
            perf_flush_r <= perf_flush_r + {31'd0, flush_s};
        end
    end

    assign o_perf_fetch = perf_fetch_r;
    assign o_perf_flush = perf_flush_r;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a memory responder with
// configurable response latency, a scoreboard of {instr, pc} pairs pushed at
// grant time and popped when the consumer accepts the head, and directed
// scenarios for back-pressure, redirect and reset.
module tb_instr_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          QDEPTH   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_unit_if bus_if ();

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_flush;
`endif

    instr_fetch_unit #(
        .RESET_PC (RESET_PC),
        .QDEPTH   (QDEPTH)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
`ifdef IFU_PERF_CNT_EN
        .o_perf_fetch (perf_fetch),
        .o_perf_flush (perf_flush),
`endif
        .bus          (bus_if)
    );

    int          err_cnt = 0;
    int          chk_cnt = 0;
    logic [63:0] exp_q[$];
    logic [31:0] pop_log[$];
    logic [31:0] exp_addr = RESET_PC;
    logic [31:0] last_gnt_addr = 32'hFFFF_FFFF;
    logic [31:0] pend_addr = 32'd0;
    logic        pend_valid = 1'b0;
    logic        pend_dropped = 1'b0;
    int          pend_cnt = 0;
    int          lat = 1;
    int          cyc = 0;
    int          first_req = -1;
    int          first_vld = -1;
    int          n_grants = 0;
    int          perf_fetch_exp = 0;
    int          perf_flush_exp = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0000)      return 32'h0050_0093;
        else if (a == 32'h0000_0004) return 32'h0010_0113;
        else                         return a ^ 32'h1357_9BDF;
    endfunction

    // One clock cycle: sample outputs, drive inputs, update the model, advance.
    task automatic run_cycle(input logic rst_v, input logic gnt_en, input logic rdy,
                             input logic redir, input logic [31:0] redir_pc,
                             input logic stray);
        logic        req_s, vld_s, rv_real, gt;
        logic [31:0] addr_s, instr_s, pc_s;
        logic [63:0] e;
        req_s   = bus_if.o_imem_req;
        vld_s   = bus_if.o_instr_vld;
        addr_s  = bus_if.o_imem_addr;
        instr_s = bus_if.o_instr;
        pc_s    = bus_if.o_pc;
        cyc++;
        if (req_s && first_req < 0) first_req = cyc;
        if (vld_s && first_vld < 0) first_vld = cyc;
        check_eq("spurious_vld", {31'd0, vld_s && (exp_q.size() == 0)}, 32'd0);
        check_eq("single_outstanding", {31'd0, req_s && pend_valid}, 32'd0);
        check_eq("req_gating", {31'd0, req_s && (exp_q.size() >= QDEPTH)}, 32'd0);

        rv_real = pend_valid && (pend_cnt == 0);
        gt      = rst_v && gnt_en && req_s;
        rst_n                = rst_v;
        bus_if.i_imem_gnt    = gt;
        bus_if.i_imem_rvalid = rv_real || stray;
        bus_if.i_imem_rdata  = stray ? 32'hDEAD_BEEF : mem_word(pend_addr);
        bus_if.i_instr_rdy   = rdy;
        bus_if.i_redirect    = redir;
        bus_if.i_redirect_pc = redir_pc;

        if (gt) begin
            check_eq("fetch_addr", addr_s, exp_addr);
            exp_q.push_back({mem_word(exp_addr), exp_addr});
            last_gnt_addr = addr_s;
            exp_addr      = exp_addr + 32'd4;
            n_grants++;
        end
        if (rst_v && vld_s && rdy && !redir) begin
            if (exp_q.size() == 0) begin
                check_eq("pop_nonempty", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                check_eq("instr", instr_s, e[63:32]);
                check_eq("pc", pc_s, e[31:0]);
                pop_log.push_back(pc_s);
            end
        end
        if (rst_v && rv_real && !pend_dropped && !redir) perf_fetch_exp++;
        if (rst_v && redir) begin
            perf_flush_exp++;
            exp_q.delete();
            exp_addr = {redir_pc[31:2], 2'b00};
            if (pend_valid) pend_dropped = 1'b1;
        end
        if (rv_real) pend_valid = 1'b0;
        else if (pend_valid) pend_cnt--;
        if (gt) begin
            pend_valid   = 1'b1;
            pend_cnt     = lat - 1;
            pend_addr    = addr_s;
            pend_dropped = redir;
        end
        if (!rst_v) begin
            exp_q.delete();
            exp_addr       = RESET_PC;
            pend_valid     = 1'b0;
            perf_fetch_exp = 0;
            perf_flush_exp = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string tag, input logic rdy);
        int g0;
        int guard;
        g0    = n_grants;
        guard = 0;
        while (n_grants == g0 && guard < 10) begin
            run_cycle(1'b1, 1'b1, rdy, 1'b0, 32'd0, 1'b0);
            guard++;
        end
        if (n_grants == g0) check_eq(tag, 32'd0, 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_req"},   {31'd0, bus_if.o_imem_req}, 32'd0);
        check_eq({tag, "_addr"},  bus_if.o_imem_addr, RESET_PC);
        check_eq({tag, "_vld"},   {31'd0, bus_if.o_instr_vld}, 32'd0);
        check_eq({tag, "_instr"}, bus_if.o_instr, 32'd0);
        check_eq({tag, "_pc"},    bus_if.o_pc, RESET_PC);
    endtask

    task automatic check_first_pop(input string tag, input int base, input logic [31:0] pc);
        if (pop_log.size() > base) check_eq(tag, pop_log[base], pc);
        else                       check_eq(tag, 32'hFFFF_FFFF, pc);
    endtask

`ifdef IFU_PERF_CNT_EN
    task automatic check_perf(input string tag);
        check_eq({tag, "_fetch"}, perf_fetch, perf_fetch_exp);
        check_eq({tag, "_flush"}, perf_flush, perf_flush_exp);
    endtask
`endif

    initial begin
        int          base;
        int          guard;
        logic [31:0] a0;
        bus_if.i_imem_gnt    = 1'b0;
        bus_if.i_imem_rvalid = 1'b0;
        bus_if.i_imem_rdata  = 32'd0;
        bus_if.i_redirect    = 1'b0;
        bus_if.i_redirect_pc = 32'd0;
        bus_if.i_instr_rdy   = 1'b0;
        @(posedge clk);
        #1;
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        check_reset_values("rst0");

        // Fetch two words with the consumer stalled; FIFO fills and requests stop.
        lat = 1;
        repeat (12) run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        check_eq("latency_req_to_vld", first_vld - first_req, 32'd2);
        check_eq("grants_when_full", n_grants, 32'd2);
        check_eq("req_low_when_full", {31'd0, bus_if.o_imem_req}, 32'd0);
        check_eq("head_pc", bus_if.o_pc, 32'h0000_0000);
        check_eq("head_instr", bus_if.o_instr, 32'h0050_0093);
        check_eq("queue_depth", exp_q.size(), 32'd2);

        // One pop frees a slot: exactly one new request, to 0x8.
        lat = 3;
        run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        wait_grant("timeout_grant_8", 1'b0);
        check_eq("refill_addr", last_gnt_addr, 32'h0000_0008);

        // Redirect while that request is outstanding; its response must be dropped.
        run_cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0103, 1'b0);
        lat  = 1;
        base = pop_log.size();
        repeat (10) run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        check_first_pop("first_pc_after_wait_redirect", base, 32'h0000_0100);
`ifdef IFU_PERF_CNT_EN
        check_perf("perf_s3");
`endif

        // Full FIFO, redirect and pop in the same cycle.
        repeat (8) run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        check_eq("full_vld", {31'd0, bus_if.o_instr_vld}, 32'd1);
        check_eq("full_req", {31'd0, bus_if.o_imem_req}, 32'd0);
        run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
        check_eq("vld_after_flush", {31'd0, bus_if.o_instr_vld}, 32'd0);
        base = pop_log.size();
        repeat (10) run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        check_first_pop("first_pc_after_full_flush", base, 32'h0000_0200);

        // Ungranted request holds; then redirect coincident with its grant.
        guard = 0;
        while (bus_if.o_imem_req !== 1'b1 && guard < 10) begin
            run_cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
            guard++;
        end
        check_eq("req_seen", {31'd0, bus_if.o_imem_req}, 32'd1);
        a0 = bus_if.o_imem_addr;
        repeat (3) run_cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        check_eq("req_held", {31'd0, bus_if.o_imem_req}, 32'd1);
        check_eq("addr_held", bus_if.o_imem_addr, a0);
        run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0301, 1'b0);
        check_eq("req_low_in_drop", {31'd0, bus_if.o_imem_req}, 32'd0);
        base = pop_log.size();
        repeat (10) run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        check_first_pop("first_pc_after_grant_redirect", base, 32'h0000_0300);

        // Reset during WAIT, followed by a stray response.
        lat = 3;
        wait_grant("timeout_grant_s5", 1'b1);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        check_reset_values("rst_wait");
`ifdef IFU_PERF_CNT_EN
        check_perf("perf_rst");
`endif
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        run_cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        run_cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        check_eq("stray_not_pushed", {31'd0, bus_if.o_instr_vld}, 32'd0);
        check_eq("req_after_rst", {31'd0, bus_if.o_imem_req}, 32'd1);
        check_eq("addr_after_rst", bus_if.o_imem_addr, RESET_PC);
        lat  = 1;
        base = pop_log.size();
        repeat (8) run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        check_first_pop("first_pc_after_rst", base, RESET_PC);

        // Redirect to a non-aligned target once more, then drain.
        run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0103, 1'b0);
        base = pop_log.size();
        repeat (8) run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        check_first_pop("first_pc_after_redirect2", base, 32'h0000_0100);
`ifdef IFU_PERF_CNT_EN
        check_perf("perf_end");
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
